md5_pad: RTL
============

MD5_PAD -- requirements
Module: md5_pad

Interface
REQ-001 SHALL have parameter: MAX_LEN, default 55, maximum message length in bytes (legal range 1..55).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset; sampled only on the rising edge of clk.
REQ-004 SHALL have port: in_byte  input  8  message byte.
REQ-005 SHALL have port: in_valid  input  1  in_byte is valid.
REQ-006 SHALL have port: in_last  input  1  in_byte is the final byte of the message; qualified by in_valid.
REQ-007 SHALL have port: in_ready  output  1  the block can accept a byte this cycle.
REQ-008 SHALL have port: mesg  output  512  padded single MD5 block, feeding md5core mesg.
REQ-009 SHALL have port: mesg_valid  output  1  mesg holds a complete padded block.
REQ-010 SHALL have port: mesg_ready  input  1  the downstream stage accepts mesg.
REQ-011 SHALL have port: too_long  output  1  the current message exceeded MAX_LEN and is being discarded.

Function
REQ-012 SHALL accept a byte on any rising edge where in_valid=1 and in_ready=1; no other edge changes the byte count.
REQ-013 SHALL place accepted byte i (i = 0 upward) at mesg[511-8i -: 8], so byte 0 sits in the MSB.
REQ-014 SHALL implement a four-state FSM: LOAD, PAD, HOLD, ERR.
REQ-015 In LOAD, SHALL drive in_ready=1, mesg_valid=0 and too_long=0; each accepted byte SHALL be written at index count, then count SHALL increment.
REQ-016 In LOAD, an accepted byte with in_last=1 and count < MAX_LEN SHALL transition the FSM to PAD.
REQ-017 In LOAD, a byte accepted while count == MAX_LEN SHALL be discarded and SHALL transition the FSM to ERR, whatever the value of in_last.
REQ-018 In PAD (exactly one cycle, in_ready=0), SHALL write 0x80 at byte index N, where N is the message length.
REQ-019 In PAD, SHALL write the bit length L = 8*N into bytes 56..63 little-endian: byte 56 = L[7:0], byte 57 = L[15:8], bytes 58..63 = 0x00; the FSM SHALL then go to HOLD.
REQ-020 All bytes not written by REQ-015, REQ-018 or REQ-019 SHALL read 0x00.
REQ-021 In HOLD, SHALL drive mesg_valid=1 and in_ready=0, and mesg SHALL stay bit-stable until the handshake edge.
REQ-022 On an edge in HOLD with mesg_ready=1, the FSM SHALL go to LOAD, clear mesg to 0 and set count to 0; mesg_ready SHALL be ignored outside HOLD.
REQ-023 Latency: if the last byte is accepted at edge k, mesg_valid SHALL be 1 from edge k+2 onward.
REQ-024 Sustained throughput SHALL be one byte per cycle in LOAD, plus a minimum of 2 dead cycles per message (PAD, plus at least one HOLD cycle).
REQ-025 In ERR, SHALL drive too_long=1 and mesg_valid=0.
REQ-026 In ERR, SHALL drive in_ready=1 and discard bytes until a byte with in_last=1 is accepted, then go to LOAD with mesg cleared and count=0.
REQ-027 If the overflow byte itself carried in_last=1, ERR SHALL last exactly one cycle with in_ready=0, then return to LOAD.
REQ-028 Zero-length messages are not supported, because in_last always travels with a byte.
REQ-029 count SHALL be 6 bits wide, and L SHALL be computed 9 bits wide (maximum 440 = 0x1B8).

Reset
REQ-030 When reset=0 at a rising edge, SHALL force: FSM to LOAD, count=0, mesg=0, mesg_valid=0, too_long=0.
REQ-031 reset SHALL take priority over every other event, including a handshake on the same edge and any ongoing LOAD, PAD, HOLD or ERR.
REQ-032 While reset=0, in_ready SHALL be 0; in_ready SHALL be 1 on the first cycle after reset returns to 1.

Verification
REQ-033 Scenario "quick fox": stream the 43 bytes "The quick brown fox jumps over the lazy dog" (0x54 ... 0x67, in_last on the 43rd byte) -> mesg SHALL be 512'h54686520_71756963_6b206272_6f776e20_666f7820_6a756d70_73206f76_65722074_6865206c_617a7920_646f6780_00000000_00000000_00000000_58010000_00000000, with mesg_valid asserted 2 edges after the last byte.
REQ-034 Scenario single byte: send 0x61 with in_last -> mesg[511:496]=16'h6180, byte 56=0x08, all other bytes 0x00.
REQ-035 Scenario maximum length: send 55 bytes of 0x41 -> byte 55=0x80, byte 56=0xB8, byte 57=0x01, too_long stays 0.
REQ-036 Scenario overflow: send 56 bytes of 0x41 -> too_long=1 from the edge after the 56th byte, mesg_valid never asserts; then send "abc" -> normal block with byte 3=0x80 and byte 56=0x18.
REQ-037 Scenario backpressure: hold mesg_ready=0 for 10 cycles in HOLD -> mesg stable, in_ready=0 and mesg_valid=1 throughout; raise mesg_ready -> the next edge clears mesg to 0 and in_ready returns to 1.
REQ-038 Scenario reset mid-load: pull reset low after 20 accepted bytes -> all outputs 0 on the following cycle; the next message "abc" SHALL produce the correct block.

Source files
------------

// File: rtl/md5_pad.sv
// md5_pad: collects a byte stream of up to MAX_LEN bytes and presents it as
// one MD5-padded 512-bit block (0x80 terminator, 64-bit little-endian bit
// length in bytes 56..63). Over-long messages are discarded up to in_last.
module md5_pad #(
    parameter int unsigned MAX_LEN = 55
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] mesg,
    output logic         mesg_valid,
    input  logic         mesg_ready,
    output logic         too_long
);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PAD  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } state_t;

    localparam logic [5:0] MAX_CNT = 6'(MAX_LEN);

    state_t       state_q, state_d;
    logic [5:0]   count_q, count_d;
    logic [511:0] mesg_q, mesg_d;
    logic         err_last_q, err_last_d;

    logic [8:0]   bitlen;
    logic [8:0]   byte_lsb;

    // Byte i occupies mesg[511-8i -: 8]; its low bit sits at 504-8i.
    assign bitlen   = {count_q, 3'b000};
    assign byte_lsb = 9'd504 - {count_q, 3'b000};
    assign mesg     = mesg_q;

    // State, byte count and block register; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= LOAD;
            count_q    <= '0;
            mesg_q     <= '0;
            err_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mesg_q     <= mesg_d;
            err_last_q <= err_last_d;
        end
    end

    // Next-state, block update and handshake outputs.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mesg_d     = mesg_q;
        err_last_d = err_last_q;
        in_ready   = 1'b0;
        mesg_valid = 1'b0;
        too_long   = 1'b0;

        case (state_q)
            LOAD: begin
                in_ready = reset;
                if (in_valid) begin
                    if (count_q == MAX_CNT) begin
                        // Overflow byte is dropped; remember whether it also
                        // ended the message so ERR can leave immediately.
                        state_d    = ERR;
                        err_last_d = in_last;
                    end else begin
                        mesg_d[byte_lsb +: 8] = in_byte;
                        count_d               = count_q + 6'd1;
                        if (in_last) begin
                            state_d = PAD;
                        end
                    end
                end
            end

            PAD: begin
                mesg_d[byte_lsb +: 8] = 8'h80;
                mesg_d[63:56]         = bitlen[7:0];
                mesg_d[55:48]         = {7'b0000000, bitlen[8]};
                mesg_d[47:0]          = '0;
                state_d               = HOLD;
            end

            HOLD: begin
                mesg_valid = 1'b1;
                if (mesg_ready) begin
                    state_d = LOAD;
                    mesg_d  = '0;
                    count_d = '0;
                end
            end

            ERR: begin
                too_long = 1'b1;
                in_ready = reset & ~err_last_q;
                if (err_last_q || (in_valid && in_last)) begin
                    state_d    = LOAD;
                    mesg_d     = '0;
                    count_d    = '0;
                    err_last_d = 1'b0;
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

endmodule
